// File: rtl/ts_pkg.sv
// Shared constants and event-word field layout for the timestamp capture block.
package ts_pkg;

  localparam int CHAN_W = 2;
  localparam int NUM_CH = 4;
  localparam int TS_LSB = 0;

  // Event word: {chan[1:0], overrun, epoch, ts[TS_W-1:0]}
  function automatic int epoch_bit(input int ts_w);
    return ts_w;
  endfunction

  function automatic int ovr_bit(input int ts_w);
    return ts_w + 1;
  endfunction

  function automatic int chan_lsb(input int ts_w);
    return ts_w + 2;
  endfunction

  function automatic int ev_w(input int ts_w);
    return ts_w + CHAN_W + 2;
  endfunction

endpackage

// File: rtl/ts_event_fifo.sv
// First-word-fall-through event FIFO with occupancy count.
module ts_event_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot for a push.
  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & valid_o;
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  // Pointer and count next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless until the count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ts_capture.sv
// Four-channel timestamp capture: synchronize, detect rising edges, stamp, arbitrate, buffer.
module ts_capture
  import ts_pkg::*;
#(
  parameter int TS_W        = 24,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          datain_ch0,
  input  logic                          datain_ch1,
  input  logic                          datain_ch2,
  input  logic                          datain_ch3,
  output logic [TS_W+3:0]               ev_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    lost_cnt
);

  localparam int EV_W      = ev_w(TS_W);
  localparam int EPOCH_BIT = epoch_bit(TS_W);
  localparam int OVR_BIT   = ovr_bit(TS_W);
  localparam int CHAN_LSB  = chan_lsb(TS_W);

  logic [NUM_CH-1:0]      din;
  logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
  logic [NUM_CH-1:0]      sync_out, hist_q, edge_det;
  logic [TS_W-1:0]        ts_q;
  logic                   epoch_q;
  logic [NUM_CH-1:0]      pend_q, pend_d, ovr_q, ovr_d, grant;
  logic [TS_W:0]          cap_q [NUM_CH];
  logic [TS_W:0]          cap_d [NUM_CH];
  logic [7:0]             lost_q, lost_d;
  logic [CHAN_W-1:0]      gnt_ch;
  logic                   push, fifo_full;
  logic [EV_W-1:0]        push_word;

  assign din      = {datain_ch3, datain_ch2, datain_ch1, datain_ch0};
  assign lost_cnt = lost_q;

  // Free-running stamp; carry out of ts toggles the epoch bit.
  always_ff @(posedge clk) begin
    if (rst) {epoch_q, ts_q} <= '0;
    else     {epoch_q, ts_q} <= {epoch_q, ts_q} + (TS_W+1)'(1);
  end

  // Input synchronizers plus one history flop per channel for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) sync_q[c] <= '0;
      hist_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], din[c]};
      hist_q <= sync_out;
    end
  end

  // Synchronizer outputs and rising-edge strobes.
  always_comb begin
    sync_out = '0;
    for (int c = 0; c < NUM_CH; c++) sync_out[c] = sync_q[c][SYNC_STAGES-1];
    edge_det = sync_out & ~hist_q;
  end

  // Fixed-priority arbiter: lowest pending channel wins when the FIFO has room.
  always_comb begin
    grant  = '0;
    gnt_ch = '0;
    push   = 1'b0;
    if (!fifo_full) begin
      for (int c = NUM_CH-1; c >= 0; c--) begin
        if (pend_q[c]) begin
          grant    = '0;
          grant[c] = 1'b1;
          gnt_ch   = CHAN_W'(c);
          push     = 1'b1;
        end
      end
    end
  end

  // Assemble the event word of the granted channel.
  always_comb begin
    push_word                     = '0;
    push_word[TS_LSB +: TS_W]     = cap_q[gnt_ch][TS_W-1:0];
    push_word[EPOCH_BIT]          = cap_q[gnt_ch][TS_W];
    push_word[OVR_BIT]            = ovr_q[gnt_ch];
    push_word[CHAN_LSB +: CHAN_W] = gnt_ch;
  end

  // Capture and overrun tracking; a grant in the same cycle frees the slot for the new edge.
  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    lost_d = lost_q;
    for (int c = 0; c < NUM_CH; c++) cap_d[c] = cap_q[c];
    for (int c = 0; c < NUM_CH; c++) begin
      if (edge_det[c]) begin
        if (pend_q[c] && !grant[c]) begin
          ovr_d[c] = 1'b1;
          if (lost_d != 8'hFF) lost_d = lost_d + 8'd1;
        end else begin
          pend_d[c] = 1'b1;
          ovr_d[c]  = 1'b0;
          cap_d[c]  = {epoch_q, ts_q};
        end
      end else if (grant[c]) begin
        pend_d[c] = 1'b0;
        ovr_d[c]  = 1'b0;
      end
    end
  end

  // Pending/overrun flags and the loss counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      ovr_q  <= '0;
      lost_q <= '0;
    end else begin
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      lost_q <= lost_d;
    end
  end

  // Per-channel stamp registers; only meaningful while the pending flag is set.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) cap_q[c] <= cap_d[c];
  end

  ts_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (ev_ready),
    .rdata_o (ev_data),
    .valid_o (ev_valid),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

endmodule

// File: doc/ts_capture.md
Name: ts_capture

Overview:
- Timestamp-capture front end of the timestamper; sits between the four raw channel inputs and the parallel-in serializer.
- Synchronizes each channel, detects rising edges, and stamps each edge with a free-running counter value.
- Arbitrates simultaneous events and buffers them in a small FIFO.
- Presents fixed-width event words to the serializer over a valid/ready handshake.

Parameters:
- TS_W, 24, timestamp counter width in bits.
- FIFO_DEPTH, 8, event FIFO depth in words; must be a power of 2, minimum 2.
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer; minimum 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- datain_ch0  in  1  asynchronous channel 0 input.
- datain_ch1  in  1  asynchronous channel 1 input.
- datain_ch2  in  1  asynchronous channel 2 input.
- datain_ch3  in  1  asynchronous channel 3 input.
- ev_data  out  TS_W+4  event word, head of FIFO.
- ev_valid  out  1  ev_data holds a valid event.
- ev_ready  in  1  serializer accepts ev_data this cycle.
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- lost_cnt  out  8  events dropped since reset; saturates at 255.

Behaviour:
- Reset: one clk with rst=1 clears all state:
  - synchronizers, edge history, pending flags, FIFO pointers, timestamp counter, epoch bit, lost_cnt;
  - ev_valid=0, ev_data=0, fifo_count=0.
- Reset mid-operation discards pending events and FIFO contents. No partial word is ever presented.
- Timestamp counter ts:
  - increments by 1 every clk;
  - wraps from 2^TS_W-1 to 0;
  - epoch bit toggles on each wrap.
- Synchronizer and edge detect:
  - per channel, SYNC_STAGES flops followed by one history flop;
  - edge = sync_out & ~hist.
  - Fixed latency from input rise to edge cycle is SYNC_STAGES+1 clks; software removes this constant offset.
- Capture: on an edge, the channel's pending flag sets and the channel latches {epoch, ts} of that cycle.
  - Each channel has its own capture register, so simultaneous edges on several channels keep identical, exact stamps.
- Overrun:
  - An edge on a channel whose pending flag is already set and not being cleared that cycle:
    - keeps the older stored stamp;
    - sets that channel's overrun bit;
    - increments lost_cnt (saturating).
  - If the pending flag is cleared in the same cycle as a new edge, the new edge is captured normally with no overrun.
- Arbiter: fixed priority, ch0 highest.
  - Each cycle, if the FIFO is not full, the lowest-numbered pending channel is pushed and its pending and overrun bits clear.
  - At most one push per cycle.
- Event word layout:
  - [TS_W+3:TS_W+2] channel number;
  - [TS_W+1] overrun (at least one later edge on this channel was lost);
  - [TS_W] epoch;
  - [TS_W-1:0] timestamp.
- FIFO:
  - first-word-fall-through; ev_valid = (count != 0);
  - pop when ev_valid & ev_ready;
  - push allowed only when not full at the start of the cycle (a pop in the same cycle does not unblock a push);
  - push and pop in the same cycle leave count unchanged;
  - ev_data is stable while ev_valid=1 and ev_ready=0;
  - ev_ready with an empty FIFO is ignored.
- Pointers wrap modulo FIFO_DEPTH. The extra count bit distinguishes full from empty.
- Throughput: one event in, one out per clk. Sustained edges faster than one per 4 clks per channel cause overruns.

Decomposition:
- Package ts_pkg holds:
  - CHAN_W=2, NUM_CH=4;
  - field offset constants (TS_LSB, EPOCH_BIT, OVR_BIT, CHAN_LSB) as functions of TS_W;
  - event word width TS_W+4.
- Sub-module ts_event_fifo is the parameterized FWFT FIFO with push/pop/count.
- Synchronizer, edge detect, capture and arbiter stay in ts_capture.

Test Plan:
- Reset, then ch0 rises once and ev_ready=1 → exactly one word, chan=0, ovr=0, ts equal to the counter value SYNC_STAGES+1 clks after the input rise; lost_cnt=0.
- ch1 and ch3 rise in the same clk → two words in consecutive cycles, ch1 first then ch3, identical ts fields.
- ev_ready=0, 10 single edges spread across channels → fifo_count saturates at 8, remaining events stay pending. Then ev_ready=1 → all delivered in priority/arrival order with no loss.
- ev_ready=0, FIFO full, ch2 pulses 3 times → ch2 word carries the first edge's ts with ovr=1; lost_cnt=2.
- Preload ts near 2^TS_W-1 (wait out 2^TS_W clks with a small TS_W override, e.g. TS_W=8) → events before and after the wrap carry epoch 0 and 1 respectively; ts restarts at 0.
- Assert rst for 1 clk while FIFO holds 5 words and 2 channels are pending → next cycle ev_valid=0, fifo_count=0, lost_cnt=0; subsequent edges are stamped from ts=0.
